// File: rtl/qam16_tx_framer.sv
// ---------------------------------------------------------------------------
// qam16_tx_framer
//
// Transmit-side symbol source for the 16-QAM MER/SER test chain. Each frame is
// a fixed alternating preamble followed by FRAME_LEN data symbols. Every data
// symbol maps 4 input bits to 4-ASK levels in signed 1s17 format on I and Q.
// The block produces two outputs:
//   - a symbol-rate output (sym_I/sym_Q)
//   - a zero-stuffed sample-rate output (up_I/up_Q) for the pulse-shaping
//     filter.
//
// Handshake (bits_in / bits_valid / bits_ready):
//   bits_ready is high only in a DATA-state symbol slot (sym_clk_en). A
//   transfer happens in a cycle where bits_ready and bits_valid are both high.
//   A DATA slot with bits_valid low still uses up the slot: the block issues
//   the zero symbol and underflow_cnt counts it. The source cannot stall the
//   framer.
//
// Ports:
//   sys_clk        system clock (single domain)
//   reset          synchronous, active-high reset
//   sam_clk_en     sample-rate enable (1 of 4 sys_clk)
//   sym_clk_en     symbol-rate enable (coincides with sam_clk_en, 1 of 4)
//   frame_start    frame request, sampled only in IDLE symbol slots
//   bits_in[3:0]   symbol bits: [1:0] -> I, [3:2] -> Q
//   bits_valid     bits_in valid
//   bits_ready     combinational: DATA state and sym_clk_en
//   sym_I/sym_Q    signed 1s17 mapped symbol, updated on symbol slots
//   up_I/up_Q      signed 1s17 zero-stuffed samples, updated on sam_clk_en
//   sym_strobe     one-cycle pulse after sym_I/sym_Q update
//   in_preamble    current sym_I/sym_Q is a preamble symbol
//   frame_done     one-cycle pulse after the last data slot of a frame
//   underflow_cnt  saturating count of data slots without valid input
//   fsm_state      debug view of the framer state (0 IDLE, 1 PREAMBLE, 2 DATA)
// ---------------------------------------------------------------------------
module qam16_tx_framer #(
  parameter int PRE_LEN    = 8,
  parameter int FRAME_LEN  = 64,
  parameter int CONTINUOUS = 0
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic               frame_start,
  input  logic [3:0]         bits_in,
  input  logic               bits_valid,
  output logic               bits_ready,
  output logic signed [17:0] sym_I,
  output logic signed [17:0] sym_Q,
  output logic signed [17:0] up_I,
  output logic signed [17:0] up_Q,
  output logic               sym_strobe,
  output logic               in_preamble,
  output logic               frame_done,
  output logic [15:0]        underflow_cnt,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_t;

  // 4-ASK levels in 1s17: +/-3/4 and +/-1/4 of full scale.
  localparam logic signed [17:0] LVL_P3 = 18'sd98304;
  localparam logic signed [17:0] LVL_P1 = 18'sd32768;
  localparam logic signed [17:0] LVL_M1 = -18'sd32768;
  localparam logic signed [17:0] LVL_M3 = -18'sd98304;

  localparam logic [7:0]  PRE_LAST  = 8'(PRE_LEN - 1);
  localparam logic [15:0] DATA_LAST = 16'(FRAME_LEN - 1);
  localparam logic [15:0] UF_MAX    = 16'hFFFF;

  function automatic logic signed [17:0] map_lvl(input logic [1:0] b);
    logic signed [17:0] lvl;
    case (b)
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b10:   lvl = LVL_P1;
      default: lvl = LVL_P3;
    endcase
    return lvl;
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         pre_cnt_q, pre_cnt_d;
  logic [15:0]        data_cnt_q, data_cnt_d;

  // Result of the current symbol slot. It is committed only when sym_clk_en
  // is high.
  logic signed [17:0] nxt_i, nxt_q;
  logic               nxt_pre;
  logic               nxt_done;
  logic               uf_inc;

  assign bits_ready = (state_q == ST_DATA) && sym_clk_en;
  assign fsm_state  = state_q;

  // Next-state and slot-output logic.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    data_cnt_d = data_cnt_q;
    nxt_i      = '0;
    nxt_q      = '0;
    nxt_pre    = 1'b0;
    nxt_done   = 1'b0;
    uf_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          // Preamble symbol 0 goes out in the requesting slot itself.
          nxt_i   = LVL_P3;
          nxt_q   = LVL_P3;
          nxt_pre = 1'b1;
          if (PRE_LEN == 1) begin
            state_d   = ST_DATA;
            pre_cnt_d = 8'd0;
          end else begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 8'd1;
          end
        end
      end

      ST_PREAMBLE: begin
        // Even index: (+3/4, +3/4). Odd index: (-3/4, -3/4).
        nxt_i   = pre_cnt_q[0] ? LVL_M3 : LVL_P3;
        nxt_q   = pre_cnt_q[0] ? LVL_M3 : LVL_P3;
        nxt_pre = 1'b1;
        if (pre_cnt_q == PRE_LAST) begin
          state_d   = ST_DATA;
          pre_cnt_d = 8'd0;
        end else begin
          pre_cnt_d = pre_cnt_q + 8'd1;
        end
      end

      ST_DATA: begin
        if (bits_valid) begin
          nxt_i = map_lvl(bits_in[1:0]);
          nxt_q = map_lvl(bits_in[3:2]);
        end else begin
          uf_inc = 1'b1;
        end
        if (data_cnt_q == DATA_LAST) begin
          data_cnt_d = 16'd0;
          nxt_done   = 1'b1;
          // In continuous mode the next slot is preamble symbol 0. pre_cnt is
          // already 0 on entry to DATA.
          state_d    = (CONTINUOUS != 0) ? ST_PREAMBLE : ST_IDLE;
        end else begin
          data_cnt_d = data_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        pre_cnt_d  = 8'd0;
        data_cnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pre_cnt_q     <= 8'd0;
      data_cnt_q    <= 16'd0;
      sym_I         <= '0;
      sym_Q         <= '0;
      up_I          <= '0;
      up_Q          <= '0;
      sym_strobe    <= 1'b0;
      in_preamble   <= 1'b0;
      frame_done    <= 1'b0;
      underflow_cnt <= 16'd0;
    end else begin
      sym_strobe <= sym_clk_en;
      frame_done <= sym_clk_en && nxt_done;

      if (sym_clk_en) begin
        state_q     <= state_d;
        pre_cnt_q   <= pre_cnt_d;
        data_cnt_q  <= data_cnt_d;
        sym_I       <= nxt_i;
        sym_Q       <= nxt_q;
        in_preamble <= nxt_pre;
        if (uf_inc && (underflow_cnt != UF_MAX)) begin
          underflow_cnt <= underflow_cnt + 16'd1;
        end
      end

      // Zero-stuffing: a symbol lands on the sample that coincides with its
      // slot; the other three samples of the symbol period are zero. A
      // symbol slot without sam_clk_en never reaches this path.
      if (sam_clk_en) begin
        up_I <= sym_clk_en ? nxt_i : 18'sd0;
        up_Q <= sym_clk_en ? nxt_q : 18'sd0;
      end
    end
  end

endmodule

// File: tb/tb_qam16_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_qam16_tx_framer
//
// Directed bench for qam16_tx_framer. It uses two instances:
//   dut_a: default parameters (PRE_LEN=8, FRAME_LEN=64, CONTINUOUS=0)
//   dut_b: PRE_LEN=1, FRAME_LEN=2, CONTINUOUS=1
// Both instances share the enables, bits_in/bits_valid and reset. Each has its
// own frame_start.
//
// A symbol slot is 16 sys_clk cycles: sym_clk_en on cycle 0, and sam_clk_en on
// cycles 0, 4, 8 and 12. For each slot, the expected symbol of each instance is
// packed as {frame_done, in_preamble, I, Q} and pushed to that instance's
// queue. The entry is popped when the slot's strobe cycle is observed.
// ---------------------------------------------------------------------------
module tb_qam16_tx_framer;

  localparam int W = 38;
  localparam logic [17:0] P3 = 18'sd98304;
  localparam logic [17:0] P1 = 18'sd32768;
  localparam logic [17:0] M1 = -18'sd32768;
  localparam logic [17:0] M3 = -18'sd98304;
  localparam logic [W-1:0] ZSYM = '0;

  // clock / reset / inputs
  logic sys_clk;
  logic reset;
  logic sam_clk_en;
  logic sym_clk_en;
  logic frame_start_a;
  logic frame_start_b;
  logic [3:0] bits_in;
  logic bits_valid;

  // dut_a outputs
  logic bits_ready_a;
  logic signed [17:0] sym_i_a, sym_q_a, up_i_a, up_q_a;
  logic sym_strobe_a, in_preamble_a, frame_done_a;
  logic [15:0] underflow_cnt_a;
  logic [1:0] fsm_state_a;

  // dut_b outputs
  logic bits_ready_b;
  logic signed [17:0] sym_i_b, sym_q_b, up_i_b, up_q_b;
  logic sym_strobe_b, in_preamble_b, frame_done_b;
  logic [15:0] underflow_cnt_b;
  logic [1:0] fsm_state_b;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [17:0] prev_ui_a, prev_uq_a, prev_ui_b, prev_uq_b;

  int n_cmp;
  int n_fail;

  qam16_tx_framer dut_a (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .sam_clk_en    (sam_clk_en),
    .sym_clk_en    (sym_clk_en),
    .frame_start   (frame_start_a),
    .bits_in       (bits_in),
    .bits_valid    (bits_valid),
    .bits_ready    (bits_ready_a),
    .sym_I         (sym_i_a),
    .sym_Q         (sym_q_a),
    .up_I          (up_i_a),
    .up_Q          (up_q_a),
    .sym_strobe    (sym_strobe_a),
    .in_preamble   (in_preamble_a),
    .frame_done    (frame_done_a),
    .underflow_cnt (underflow_cnt_a),
    .fsm_state     (fsm_state_a)
  );

  qam16_tx_framer #(
    .PRE_LEN    (1),
    .FRAME_LEN  (2),
    .CONTINUOUS (1)
  ) dut_b (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .sam_clk_en    (sam_clk_en),
    .sym_clk_en    (sym_clk_en),
    .frame_start   (frame_start_b),
    .bits_in       (bits_in),
    .bits_valid    (bits_valid),
    .bits_ready    (bits_ready_b),
    .sym_I         (sym_i_b),
    .sym_Q         (sym_q_b),
    .up_I          (up_i_b),
    .up_Q          (up_q_b),
    .sym_strobe    (sym_strobe_b),
    .in_preamble   (in_preamble_b),
    .frame_done    (frame_done_b),
    .underflow_cnt (underflow_cnt_b),
    .fsm_state     (fsm_state_b)
  );

  // clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ---------------- helpers ----------------
  function automatic logic [17:0] lvl(input logic [1:0] b);
    logic [17:0] r;
    case (b)
      2'b00:   r = M3;
      2'b01:   r = M1;
      2'b10:   r = P1;
      default: r = P3;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] ex(input logic done, input logic pre,
                                      input logic [17:0] i, input logic [17:0] q);
    return {done, pre, i, q};
  endfunction

  function automatic logic [W-1:0] dsym(input logic [3:0] b, input logic v,
                                        input logic done);
    return v ? ex(done, 1'b0, lvl(b[1:0]), lvl(b[3:2])) : ex(done, 1'b0, 18'd0, 18'd0);
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {17'd0, obs}, {17'd0, exp});
  endtask

  // Checks one instance after a clock edge. sy/sa are the enables that were
  // applied at that edge. pui/puq are the sample outputs seen one cycle earlier.
  task automatic check_dut(input string tag, input logic sy, input logic sa,
                           input logic strobe, input logic pre, input logic done,
                           input logic [17:0] si, input logic [17:0] sq,
                           input logic [17:0] ui, input logic [17:0] uq,
                           input logic [17:0] pui, input logic [17:0] puq,
                           input logic [W-1:0] e);
    chk1({tag, "_strobe"}, strobe, sy);
    if (sy) begin
      chk({tag, "_sym_i"}, si, e[35:18]);
      chk({tag, "_sym_q"}, sq, e[17:0]);
      chk1({tag, "_in_preamble"}, pre, e[36]);
      chk1({tag, "_frame_done"}, done, e[37]);
      chk({tag, "_up_i_sym"}, ui, e[35:18]);
      chk({tag, "_up_q_sym"}, uq, e[17:0]);
    end else begin
      chk1({tag, "_frame_done_quiet"}, done, 1'b0);
      if (sa) begin
        chk({tag, "_up_i_stuff"}, ui, 18'd0);
        chk({tag, "_up_q_stuff"}, uq, 18'd0);
      end else begin
        chk({tag, "_up_i_hold"}, ui, pui);
        chk({tag, "_up_q_hold"}, uq, puq);
      end
    end
  endtask

  // Driver: one 16-cycle symbol slot. Must be called just after a negedge.
  task automatic slot(input logic fs_a, input logic fs_b, input logic [3:0] b,
                      input logic v, input logic rdy_a, input logic rdy_b,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    for (int c = 0; c < 16; c++) begin
      sym_clk_en    = (c == 0);
      sam_clk_en    = (c % 4 == 0);
      frame_start_a = (c == 0) ? fs_a : 1'b0;
      frame_start_b = (c == 0) ? fs_b : 1'b0;
      bits_in       = b;
      bits_valid    = v;
      #1;
      chk1("a_bits_ready", bits_ready_a, (c == 0) ? rdy_a : 1'b0);
      chk1("b_bits_ready", bits_ready_b, (c == 0) ? rdy_b : 1'b0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      pa = ZSYM;
      pb = ZSYM;
      if (sym_clk_en) begin
        if (exp_a_q.size() == 0) begin
          n_cmp++; n_fail++;
          $error("FAIL a_scoreboard_empty: observed 0 entries expected 1");
        end else pa = exp_a_q.pop_front();
        if (exp_b_q.size() == 0) begin
          n_cmp++; n_fail++;
          $error("FAIL b_scoreboard_empty: observed 0 entries expected 1");
        end else pb = exp_b_q.pop_front();
      end
      check_dut("a", sym_clk_en, sam_clk_en, sym_strobe_a, in_preamble_a, frame_done_a,
                sym_i_a, sym_q_a, up_i_a, up_q_a, prev_ui_a, prev_uq_a, pa);
      check_dut("b", sym_clk_en, sam_clk_en, sym_strobe_b, in_preamble_b, frame_done_b,
                sym_i_b, sym_q_b, up_i_b, up_q_b, prev_ui_b, prev_uq_b, pb);
      prev_ui_a = up_i_a; prev_uq_a = up_q_a;
      prev_ui_b = up_i_b; prev_uq_b = up_q_b;
    end
  endtask

  // Reset pulse, applied together with a symbol slot and frame_start to show
  // that reset wins. Must be called just after a negedge.
  task automatic do_reset(input logic en);
    reset         = 1'b1;
    sym_clk_en    = en;
    sam_clk_en    = en;
    frame_start_a = 1'b1;
    frame_start_b = 1'b1;
    bits_in       = 4'hF;
    bits_valid    = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_a_sym_i", sym_i_a, 18'd0);
    chk("rst_a_sym_q", sym_q_a, 18'd0);
    chk("rst_a_up_i", up_i_a, 18'd0);
    chk("rst_a_up_q", up_q_a, 18'd0);
    chk1("rst_a_strobe", sym_strobe_a, 1'b0);
    chk1("rst_a_in_preamble", in_preamble_a, 1'b0);
    chk1("rst_a_frame_done", frame_done_a, 1'b0);
    chk("rst_a_underflow", {2'b00, underflow_cnt_a}, 18'd0);
    chk("rst_a_state", {16'd0, fsm_state_a}, 18'd0);
    chk("rst_b_sym_i", sym_i_b, 18'd0);
    chk("rst_b_up_i", up_i_b, 18'd0);
    chk1("rst_b_strobe", sym_strobe_b, 1'b0);
    chk1("rst_b_in_preamble", in_preamble_b, 1'b0);
    chk("rst_b_underflow", {2'b00, underflow_cnt_b}, 18'd0);
    chk("rst_b_state", {16'd0, fsm_state_b}, 18'd0);
    reset         = 1'b0;
    sym_clk_en    = 1'b0;
    sam_clk_en    = 1'b0;
    frame_start_a = 1'b0;
    frame_start_b = 1'b0;
    bits_valid    = 1'b0;
    prev_ui_a = '0; prev_uq_a = '0; prev_ui_b = '0; prev_uq_b = '0;
  endtask

  function automatic logic is_uf(input int k);
    return (k == 3) || (k == 17) || (k == 40) || (k == 41) || (k == 63);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] pat [4];
    logic [3:0] b;
    logic v;
    pat[0] = 4'h0; pat[1] = 4'h5; pat[2] = 4'hA; pat[3] = 4'hF;
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    frame_start_a = 1'b0;
    frame_start_b = 1'b0;
    bits_in = 4'h0;
    bits_valid = 1'b0;
    prev_ui_a = '0; prev_uq_a = '0; prev_ui_b = '0; prev_uq_b = '0;
    @(negedge sys_clk);
    do_reset(1'b1);

    // 20 idle slots: zero symbol, no ready.
    for (int k = 0; k < 20; k++) begin
      b = 4'($urandom_range(0, 15));
      v = 1'($urandom_range(0, 1));
      slot(1'b0, 1'b0, b, v, 1'b0, 1'b0, ZSYM, ZSYM);
    end

    // Frame on dut_a: preamble of 8 symbols, then 64 data slots with 5
    // underflow slots (the last slot is one of them). frame_start held in one
    // data slot must be ignored.
    slot(1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b1, P3, P3), ZSYM);
    for (int k = 1; k < 8; k++) begin
      b = 4'($urandom_range(0, 15));
      slot(1'b0, 1'b0, b, 1'b1, 1'b0, 1'b0,
           (k % 2 == 1) ? ex(1'b0, 1'b1, M3, M3) : ex(1'b0, 1'b1, P3, P3), ZSYM);
    end
    for (int k = 0; k < 64; k++) begin
      b = pat[k % 4];
      v = !is_uf(k);
      slot((k == 10), 1'b0, b, v, 1'b1, 1'b0, dsym(b, v, (k == 63)), ZSYM);
    end
    slot(1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, ZSYM, ZSYM);
    chk("a_underflow_after_frame", {2'b00, underflow_cnt_a}, 18'd5);
    chk("a_state_idle_after_frame", {16'd0, fsm_state_a}, 18'd0);

    // Second dut_a frame: reset arrives during data slot 30.
    slot(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b1, P3, P3), ZSYM);
    for (int k = 1; k < 8; k++) begin
      slot(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0,
           (k % 2 == 1) ? ex(1'b0, 1'b1, M3, M3) : ex(1'b0, 1'b1, P3, P3), ZSYM);
    end
    for (int k = 0; k < 30; k++) begin
      b = 4'($urandom_range(0, 15));
      slot(1'b0, 1'b0, b, 1'b1, 1'b1, 1'b0, dsym(b, 1'b1, 1'b0), ZSYM);
    end
    do_reset(1'b1);
    slot(1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, ZSYM, ZSYM);
    // A fresh request restarts from preamble symbol 0.
    slot(1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b1, P3, P3), ZSYM);
    slot(1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b1, M3, M3), ZSYM);
    slot(1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b1, P3, P3), ZSYM);
    do_reset(1'b0);

    // dut_b: PRE_LEN=1, FRAME_LEN=2, continuous. Slot pattern after start:
    // data, data+done, preamble, data, ... with no idle slot between frames.
    slot(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, ZSYM, ex(1'b0, 1'b1, P3, P3));
    for (int j = 0; j < 9; j++) begin
      b = 4'($urandom_range(0, 15));
      v = (j != 4);
      if (j % 3 == 2)
        slot(1'b0, 1'b0, b, v, 1'b0, 1'b0, ZSYM, ex(1'b0, 1'b1, P3, P3));
      else
        slot(1'b0, 1'b0, b, v, 1'b0, 1'b1, ZSYM, dsym(b, v, (j % 3 == 1)));
    end
    chk("b_underflow", {2'b00, underflow_cnt_b}, 18'd1);
    chk("a_underflow_idle", {2'b00, underflow_cnt_a}, 18'd0);

    chk("a_scoreboard_drained", 18'(exp_a_q.size()), 18'd0);
    chk("b_scoreboard_drained", 18'(exp_b_q.size()), 18'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/qam16_tx_framer.md
Name: qam16_tx_framer

Overview:
- Transmit-side source for the 16-QAM MER/SER test chain; the inverse of the slicer and reference-mapper path.
- Accepts 4-bit symbols (I bits [1:0], Q bits [3:2]) from a bit source such as the 22-bit LFSR, using a ready/valid handshake.
- Prepends a fixed preamble to each frame and maps bits to 1s17 4-ASK levels on I and Q.
- Produces a symbol-rate output and a zero-stuffed sample-rate output for the pulse-shaping filter / DUT.

Parameters:
- PRE_LEN, 8, preamble length in symbols (1..255).
- FRAME_LEN, 64, data symbols per frame (1..65535).
- CONTINUOUS, 0, 1 = start the next preamble immediately after DATA; 0 = return to IDLE.

Ports:
- sys_clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- sam_clk_en  input  1  sample-rate enable (1 of 4 sys_clk).
- sym_clk_en  input  1  symbol-rate enable; always coincident with sam_clk_en (1 of 4 sam_clk_en).
- frame_start  input  1  request to begin a frame; level-sampled in IDLE.
- bits_in  input  4  symbol bits; [1:0] I, [3:2] Q.
- bits_valid  input  1  bits_in valid.
- bits_ready  output  1  combinational; = (state==DATA) & sym_clk_en.
- sym_I, sym_Q  output  18  signed 1s17 mapped symbol, symbol rate.
- up_I, up_Q  output  18  signed 1s17 zero-stuffed samples, sample rate.
- sym_strobe  output  1  one-sys_clk pulse the cycle after sym_I/sym_Q update.
- in_preamble  output  1  high while the current sym_I/sym_Q is a preamble symbol.
- frame_done  output  1  one-cycle pulse after the last data symbol is issued.
- underflow_cnt  output  16  count of data slots with no valid input; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, sys_clk edge with reset=1):
  - state=IDLE.
  - sym_I, sym_Q, up_I, up_Q = 0.
  - sym_strobe, in_preamble, frame_done = 0.
  - underflow_cnt = 0; internal counters = 0.
  - Reset overrides all enables, including mid-frame; no partial-frame output after reset.
- Mapping, bits to level (per rail):
  - 00 -> -98304 (-3/4)
  - 01 -> -32768 (-1/4)
  - 10 -> +32768 (+1/4)
  - 11 -> +98304 (+3/4)
  - Output is exactly 18 bits, no rounding.
  - Zero symbol = 0 on both rails.
- FSM states: IDLE, PREAMBLE, DATA. All transitions occur only on sym_clk_en cycles.
- IDLE:
  - Symbol output is the zero symbol.
  - On sym_clk_en with frame_start=1: go to PREAMBLE; the first preamble symbol is issued in that same slot.
- PREAMBLE:
  - Symbol k (k = 0..PRE_LEN-1) is I=+3/4, Q=+3/4 for even k, and I=-3/4, Q=-3/4 for odd k.
  - in_preamble=1.
  - After symbol PRE_LEN-1, go to DATA.
- DATA:
  - Each sym_clk_en slot issues one symbol.
  - If bits_valid=1: map bits_in; this counts as a transfer.
  - If bits_valid=0: issue the zero symbol, increment underflow_cnt (saturating); the slot still counts toward FRAME_LEN.
  - After slot FRAME_LEN-1, pulse frame_done on the next sys_clk.
  - Then go to PREAMBLE if CONTINUOUS=1, otherwise IDLE.
  - frame_start is ignored outside IDLE.
- Timing:
  - sym_I/sym_Q register on the sym_clk_en edge (1 sys_clk latency from the slot).
  - sym_strobe pulses on the cycle after that edge.
- Upsampler, on each sam_clk_en:
  - If sym_clk_en is also high: up_I/up_Q <= the newly mapped value, same value written to sym_I/sym_Q.
  - Otherwise: up_I/up_Q <= 0.
  - Between sam_clk_en pulses, outputs hold.
- Boundary cases:
  - sym_clk_en without sam_clk_en: illegal; the block treats it as a symbol slot and the upsampler ignores it.
  - PRE_LEN=1: exactly one +3/4 preamble symbol.
  - FRAME_LEN=1: frame_done pulses after one data slot.
  - underflow_cnt is cleared only by reset.

Test Plan:
- Reset, then 20 sym_clk_en pulses with frame_start=0 -> sym_I=sym_Q=0, bits_ready never high, up_I stays 0.
- frame_start=1 for one slot, PRE_LEN=8 -> eight symbols alternating +98304/-98304 on both rails, in_preamble=1, then in_preamble=0.
- DATA with bits_in cycling 0x0,0x5,0xA,0xF and bits_valid=1 -> (I,Q) = (-98304,-98304), (-32768,-32768), (+32768,+32768), (+98304,+98304); up_I non-zero on 1 of every 4 sam_clk_en, zero on the other three.
- FRAME_LEN=64 with bits_valid low in 5 slots -> 5 zero symbols, underflow_cnt=5, frame_done pulses exactly once after 64 data slots, state back to IDLE.
- CONTINUOUS=1 -> a preamble follows immediately after frame_done with no IDLE slot.
- Assert reset mid-DATA (slot 30) -> all outputs 0 on the next cycle, state IDLE, underflow_cnt=0; a fresh frame_start restarts from preamble symbol 0.
